// File: rtl/div_sign_ctrl_pkg.sv
// Shared definitions for the divider sign front-end.
//   DIV_XLEN      default operand/result width
//   DIV_OP_*      request opcode encodings (bit 1 selects remainder, bit 0 selects unsigned)
//   state_t       one-hot FSM state encoding, also exported on the debug port
//   op_is_signed  / op_is_rem : opcode decode helpers
package div_sign_ctrl_pkg;

    localparam int DIV_XLEN = 16;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_ISSUE = 5'b00010,
        S_WAIT  = 5'b00100,
        S_DRAIN = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_sign_ctrl_if.sv
// Execute-stage side of the divider front-end: request port, flush and
// response port.
//   req_valid/req_ready/req_op/req_a/req_b : request channel
//   flush                                  : kill any in-flight op
//   resp_valid/resp_ready/resp_data        : result channel
// Handshake rule for both channels: a transfer happens on a clock edge where
// valid and ready are both high; the sender holds valid and its payload
// stable until that edge, and valid never waits on ready.
interface div_sign_ctrl_if #(
    parameter int XLEN = 16
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            flush;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;

    // Execute stage drives requests and consumes responses.
    modport master (
        output req_valid, req_op, req_a, req_b, flush, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    // The divider front-end block.
    modport slave (
        input  req_valid, req_op, req_a, req_b, flush, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate (modulo 2^W).
//   val  in  W  input value
//   neg  in  1  negate when high
//   res  out W  neg ? -val : val
// Negating the most negative value returns it unchanged, which read as
// unsigned is exactly its magnitude.
module div_sign_fix #(
    parameter int W = 16
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);
    always_comb begin
        res = val;
        if (neg) begin
            res = {W{1'b0}} - val;
        end
    end
endmodule

// File: rtl/div_sign_ctrl.sv
// Signed/unsigned front-end and result stage for the multicycle unsigned
// divider. Converts operands to magnitudes, starts the divider, applies the
// sign fix-up to its result and holds the response until writeback takes it.
// Divide-by-zero and signed overflow are answered locally.
//   clk, rst      clock, asynchronous active-high reset
//   ex            execute-stage request/flush/response port (slave side)
//   div_start     one-cycle start pulse to the divider
//   div_dividend  registered |a|, stable until the divider's result pulse
//   div_divisor   registered |b|, same timing
//   div_ready     divider idle
//   div_vld       divider result pulse
//   div_quot      divider quotient
//   div_rem       divider remainder
//   dbg_state     current FSM state
module div_sign_ctrl
    import div_sign_ctrl_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    div_sign_ctrl_if.slave  ex,
    output logic            div_start,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic            div_ready,
    input  logic            div_vld,
    input  logic [XLEN-1:0] div_quot,
    input  logic [XLEN-1:0] div_rem,
    output state_t          dbg_state
);

    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES_VAL = {XLEN{1'b1}};

    state_t          state_q, state_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] dividend_q, dividend_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;

    logic            accept;
    logic            req_signed;
    logic            a_neg;
    logic            b_neg;
    logic            b_zero;
    logic            sig_ovf;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] q_out;
    logic [XLEN-1:0] r_out;

    assign ex.req_ready  = (state_q == S_IDLE) & ~ex.flush;
    assign ex.resp_valid = (state_q == S_DONE);
    assign ex.resp_data  = resp_data_q;
    assign div_dividend  = dividend_q;
    assign div_divisor   = divisor_q;
    assign dbg_state     = state_q;

    // Only ISSUE can start, so a start never shares a cycle with its own
    // accept; flush in ISSUE suppresses the pulse.
    assign div_start = (state_q == S_ISSUE) & div_ready & ~ex.flush;

    assign accept     = ex.req_valid & ex.req_ready;
    assign req_signed = op_is_signed(ex.req_op);
    assign a_neg      = req_signed & ex.req_a[XLEN-1];
    assign b_neg      = req_signed & ex.req_b[XLEN-1];
    assign b_zero     = (ex.req_b == '0);
    assign sig_ovf    = req_signed & (ex.req_a == MIN_VAL) & (ex.req_b == ONES_VAL);

    div_sign_fix #(.W(XLEN)) u_abs_a (.val(ex.req_a), .neg(a_neg),      .res(abs_a));
    div_sign_fix #(.W(XLEN)) u_abs_b (.val(ex.req_b), .neg(b_neg),      .res(abs_b));
    div_sign_fix #(.W(XLEN)) u_fix_q (.val(div_quot), .neg(neg_quot_q), .res(q_out));
    div_sign_fix #(.W(XLEN)) u_fix_r (.val(div_rem),  .neg(neg_rem_q),  .res(r_out));

    always_comb begin
        state_d     = state_q;
        is_rem_d    = is_rem_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        resp_data_d = resp_data_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    is_rem_d   = op_is_rem(ex.req_op);
                    neg_quot_d = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    dividend_d = abs_a;
                    divisor_d  = abs_b;
                    if (b_zero) begin
                        // Divide by zero: quotient all-ones, remainder is the raw dividend.
                        state_d     = S_DONE;
                        resp_data_d = op_is_rem(ex.req_op) ? ex.req_a : ONES_VAL;
                    end else if (sig_ovf) begin
                        // MIN / -1 overflows: quotient wraps to MIN, remainder 0.
                        state_d     = S_DONE;
                        resp_data_d = op_is_rem(ex.req_op) ? '0 : MIN_VAL;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (ex.flush) begin
                    state_d = S_IDLE;
                end else if (div_start) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (div_vld) begin
                    if (ex.flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d     = S_DONE;
                        resp_data_d = is_rem_q ? r_out : q_out;
                    end
                end else if (ex.flush) begin
                    // The divider cannot be aborted; wait out its result.
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (div_vld) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (ex.resp_ready || ex.flush) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            is_rem_q    <= 1'b0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            is_rem_q    <= is_rem_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            resp_data_q <= resp_data_d;
        end
    end

endmodule
